// File: rtl/df_tap_sequencer.sv
// ============================================================================
// df_tap_sequencer: time-multiplexed FIR tap sequencer driving a shared
// external saturating adder, one tap per cycle.   Rev 1.0
// ============================================================================
`default_nettype none

module df_tap_sequencer #(
  parameter int TAPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [TAPS-1:0]       coef_en,
  input  logic [TAPS-1:0]       coef_sign,
  input  logic [3*TAPS-1:0]     coef_shift,
  output logic [8:0]            add_a,
  output logic [8:0]            add_b,
  input  logic [7:0]            add_sum,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state_q;
  logic [7:0]          d_q [TAPS];
  logic [TAPS-1:0]     en_q;
  logic [TAPS-1:0]     sign_q;
  logic [3*TAPS-1:0]   shift_q;
  logic [7:0]          acc_q;
  logic [IW-1:0]       idx_q;
  logic [7:0]          out_data_q;

  logic [7:0]          tap_sample;
  logic [2:0]          tap_shift;
  logic [7:0]          term;

  always_comb begin
    tap_sample = d_q[idx_q];
    tap_shift  = shift_q[3*int'(idx_q) +: 3];
    term       = tap_sample >> tap_shift;
    add_a      = 9'd0;
    add_b      = 9'd0;
    if (state_q == ACC) begin
      add_a = {1'b0, acc_q};
      if (en_q[idx_q]) begin
        add_b = sign_q[idx_q] ? (9'd0 - {1'b0, term}) : {1'b0, term};
      end
    end
  end

  // Handshake outputs are gated by rst so nothing is advertised during reset.
  assign in_ready  = !rst && (state_q == IDLE) && !flush;
  assign out_valid = !rst && (state_q == OUT);
  assign busy      = !rst && (state_q != IDLE);
  assign out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int k = 0; k < TAPS; k++) d_q[k] <= 8'd0;
      en_q       <= '0;
      sign_q     <= '0;
      shift_q    <= '0;
      acc_q      <= 8'd0;
      idx_q      <= '0;
      out_data_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int k = 0; k < TAPS; k++) d_q[k] <= 8'd0;
          end else if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) d_q[k] <= d_q[k-1];
            d_q[0]  <= in_data;
            en_q    <= coef_en;
            sign_q  <= coef_sign;
            shift_q <= coef_shift;
            acc_q   <= 8'd0;
            idx_q   <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= add_sum;
          idx_q <= idx_q + 1'b1;
          // Capture the final sum directly so out_data equals acc throughout OUT.
          if (idx_q == LAST_IDX) begin
            out_data_q <= add_sum;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
